// File: rtl/lcd_pkg.sv
// Shared LCD-controller definitions: poller state encoding and display-slot field widths.
package lcd_pkg;

  localparam int SLOT_W  = 6;
  localparam int NAME_W  = 40;
  localparam int VALUE_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EMIT  = 2'd2,
    NEXT  = 2'd3
  } poll_state_t;

  // One captured display slot as handed to the text renderer.
  typedef struct packed {
    logic [SLOT_W-1:0]  slot;
    logic [NAME_W-1:0]  name;
    logic [VALUE_W-1:0] value;
  } slot_rec_t;

endpackage

// File: rtl/poll_refresh_timer.sv
// Sweep scheduler for display_poller: idle down-counter reloaded at sweep end, plus a latch
// that remembers force requests arriving mid-sweep. o_expire is combinational, valid in idle only.
module poll_refresh_timer
  import lcd_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_idle,
  input  logic i_start,
  input  logic i_load,
  input  logic i_force,
  output logic o_expire
);

  localparam int TW = $clog2(REFRESH_CYCLES + 1);

  logic [TW-1:0] r_timer;
  logic          r_pending;
  logic          w_timer_zero;

  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (i_load) begin
      r_timer <= TW'(REFRESH_CYCLES);
    end else if (i_idle && !w_timer_zero) begin
      r_timer <= r_timer - TW'(1);
    end
  end

  // Requests seen in idle start a sweep directly, so only mid-sweep pulses need latching.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= 1'b0;
    end else if (i_start) begin
      r_pending <= 1'b0;
    end else if (i_force && !i_idle) begin
      r_pending <= 1'b1;
    end
  end

  assign o_expire = i_idle && (w_timer_zero || r_pending || i_force);

endmodule

// File: rtl/display_poller.sv
// Display-slot poller: sweeps slots 1..NUM_SLOTS, waits SETTLE cycles per slot for the registered
// responder, and forwards valid slots over a valid/ready record stream (stall holds the record).
module display_poller
  import lcd_pkg::*;
#(
  parameter int NUM_SLOTS      = 44,
  parameter int SETTLE         = 2,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               force_refresh,
  output logic [SLOT_W-1:0]  display_number,
  input  logic               display_valid,
  input  logic [NAME_W-1:0]  display_name,
  input  logic [VALUE_W-1:0] display_value,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [SLOT_W-1:0]  rec_slot,
  output logic [NAME_W-1:0]  rec_name,
  output logic [VALUE_W-1:0] rec_value,
  output logic               sweep_done,
  output logic [15:0]        sweep_cnt,
  output logic               busy
);

  localparam int                SW          = $clog2(SETTLE + 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(NUM_SLOTS);

  poll_state_t       r_state;
  poll_state_t       w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] r_disp;
  logic [SW-1:0]     r_settle;
  slot_rec_t         r_rec;
  logic              r_rec_valid;
  logic              r_sweep_done;
  logic [15:0]       r_sweep_cnt;

  logic w_expire;
  logic w_start;
  logic w_capture;
  logic w_handshake;
  logic w_advance;
  logic w_wrap;

  poll_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_idle   (r_state == IDLE),
    .i_start  (w_start),
    .i_load   (w_wrap),
    .i_force  (force_refresh),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_handshake = 1'b0;
    w_advance   = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_expire) begin
          w_start     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_settle == SETTLE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = display_valid ? EMIT : NEXT;
        end
      end
      EMIT: begin
        if (rec_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (r_slot == LAST_SLOT) begin
          w_wrap      = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slot pointer and the registered request driven to the responder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot   <= '0;
      r_disp   <= '0;
      r_settle <= '0;
    end else begin
      if (w_start) begin
        r_slot <= SLOT_W'(1);
        r_disp <= SLOT_W'(1);
      end else if (w_advance) begin
        r_slot <= r_slot + SLOT_W'(1);
        r_disp <= r_slot + SLOT_W'(1);
      end else if (w_wrap) begin
        r_disp <= '0;
      end

      if (w_start || w_advance) begin
        r_settle <= '0;
      end else if (r_state == ISSUE) begin
        r_settle <= r_settle + SW'(1);
      end
    end
  end

  // Record capture; fields are frozen from capture until the renderer takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rec       <= '0;
      r_rec_valid <= 1'b0;
    end else if (w_capture) begin
      r_rec.slot  <= r_slot;
      r_rec.name  <= display_name;
      r_rec.value <= display_value;
      r_rec_valid <= display_valid;
    end else if (w_handshake) begin
      r_rec_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sweep_done <= 1'b0;
      r_sweep_cnt  <= '0;
    end else begin
      r_sweep_done <= w_wrap;
      if (w_wrap) begin
        r_sweep_cnt <= r_sweep_cnt + 16'd1;
      end
    end
  end

  assign display_number = r_disp;
  assign rec_valid      = r_rec_valid;
  assign rec_slot       = r_rec.slot;
  assign rec_name       = r_rec.name;
  assign rec_value      = r_rec.value;
  assign sweep_done     = r_sweep_done;
  assign sweep_cnt      = r_sweep_cnt;
  assign busy           = (r_state != IDLE);

  a_disp_range: assert property (@(posedge clk) disable iff (reset)
    display_number <= LAST_SLOT);
  a_rec_hold: assert property (@(posedge clk) disable iff (reset)
    rec_valid && !rec_ready |=> rec_valid && $stable(r_rec));
  a_done_pulse: assert property (@(posedge clk) disable iff (reset)
    sweep_done |=> !sweep_done);

endmodule

// File: tb/tb_display_poller.sv
// Randomised bench for display_poller: a slot-walking reference model checks every cycle,
// directed phases pin sweep timing, stall, forced refresh and mid-record reset.
module tb_display_poller;

  localparam int NSLOT   = 44;
  localparam int SETTLE  = 2;
  localparam int REFRESH = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        force_refresh;
  logic [5:0]  display_number;
  logic        resp_vld;
  logic [39:0] resp_name;
  logic [31:0] resp_val;
  logic        rec_valid;
  logic        rec_ready;
  logic [5:0]  rec_slot;
  logic [39:0] rec_name;
  logic [31:0] rec_value;
  logic        sweep_done;
  logic [15:0] sweep_cnt;
  logic        busy;

  display_poller #(
    .NUM_SLOTS(NSLOT), .SETTLE(SETTLE), .REFRESH_CYCLES(REFRESH)
  ) dut (
    .clk(clk), .reset(reset), .force_refresh(force_refresh),
    .display_number(display_number), .display_valid(resp_vld),
    .display_name(resp_name), .display_value(resp_val),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_slot(rec_slot),
    .rec_name(rec_name), .rec_value(rec_value), .sweep_done(sweep_done),
    .sweep_cnt(sweep_cnt), .busy(busy)
  );

  always #50 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Responder tables; outputs are registered one cycle behind display_number.
  logic        tb_valid [0:63];
  logic [39:0] tb_name  [0:63];
  logic [31:0] tb_val   [0:63];

  always @(posedge clk) begin
    resp_vld  <= tb_valid[display_number];
    resp_name <= tb_name[display_number];
    resp_val  <= tb_val[display_number];
  end

  int rel_cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) rel_cyc <= 0;
    else       rel_cyc <= rel_cyc + 1;
  end

  // Stimulus knobs, written only by the main sequence.
  int rdy_mode    = 0;
  int stall_slot  = 0;
  int stall_sweep = 0;
  int stall_len   = 0;
  int force_at1   = -1;
  int force_at2   = -1;

  initial begin : driver
    int stall_cnt;
    stall_cnt     = 0;
    rec_ready     = 1'b1;
    force_refresh = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) stall_cnt = 0;
      case (rdy_mode)
        0: rec_ready = 1'b1;
        1: rec_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (rec_valid && rec_slot == 6'(stall_slot) && sweep_cnt == 16'(stall_sweep)
              && stall_cnt < stall_len) begin
            rec_ready = 1'b0;
            stall_cnt++;
          end else begin
            rec_ready = 1'b1;
          end
        end
      endcase
      force_refresh = !reset && (rel_cyc == force_at1 || rel_cyc == force_at2 ||
                                 (rdy_mode == 1 && $urandom_range(0, 149) == 0));
    end
  end

  // Observations used by the directed phases; cleared while reset is held.
  int done_t[$];
  int hs_slots[$];
  int v4cnt;
  bit any_rv;

  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        done_t.delete();
        hs_slots.delete();
        v4cnt  = 0;
        any_rv = 1'b0;
      end else begin
        if (sweep_done) done_t.push_back(rel_cyc);
        if (rec_valid) any_rv = 1'b1;
        if (rec_valid && rec_slot == 6'd4) v4cnt++;
        if (rec_valid && rec_ready) hs_slots.push_back(int'(rec_slot));
      end
    end
  end

  // Reference model: walks one sweep slot by slot, one observation per cycle.
  int m_sweeps = 0;
  int m_tmr    = 0;
  bit m_pend   = 1'b0;
  bit m_done   = 1'b0;

  task automatic step();
    @(negedge clk); #1;
  endtask

  function automatic void chk_state(input int dn, input bit rv, input bit sd, input bit bz);
    chk("display_number", display_number, dn);
    chk("rec_valid", rec_valid, rv);
    chk("sweep_done", sweep_done, sd);
    chk("busy", busy, bz);
    chk("sweep_cnt", sweep_cnt, m_sweeps);
  endfunction

  task automatic model_idle(output bit ab);
    ab = 1'b0;
    forever begin
      if (reset) begin ab = 1'b1; return; end
      chk_state(0, 1'b0, m_done, 1'b0);
      m_done = 1'b0;
      if (m_pend || force_refresh || m_tmr == 0) begin
        m_pend = 1'b0;
        return;
      end
      m_tmr--;
      step();
    end
  endtask

  task automatic model_sweep(output bit ab);
    bit hs;
    ab = 1'b1;
    for (int s = 1; s <= NSLOT; s++) begin
      for (int c = 0; c < SETTLE; c++) begin
        step(); if (reset) return;
        chk_state(s, 1'b0, 1'b0, 1'b1);
        m_pend |= force_refresh;
      end
      if (tb_valid[s]) begin
        hs = 1'b0;
        while (!hs) begin
          step(); if (reset) return;
          chk_state(s, 1'b1, 1'b0, 1'b1);
          chk("rec_slot", rec_slot, s);
          chk("rec_name", rec_name, tb_name[s]);
          chk("rec_value", rec_value, tb_val[s]);
          hs = rec_ready;
          m_pend |= force_refresh;
        end
      end
      step(); if (reset) return;
      chk_state(s, 1'b0, 1'b0, 1'b1);
      m_pend |= force_refresh;
    end
    m_sweeps++;
    m_done = 1'b1;
    m_tmr  = REFRESH;
    step();
    ab = 1'b0;
  endtask

  initial begin : model
    bit ab;
    step();
    forever begin
      if (reset) begin
        m_sweeps = 0;
        m_tmr    = 0;
        m_pend   = 1'b0;
        m_done   = 1'b0;
        chk_state(0, 1'b0, 1'b0, 1'b0);
        chk("reset rec_slot", rec_slot, 0);
        chk("reset rec_name", rec_name, 0);
        chk("reset rec_value", rec_value, 0);
        step();
      end else begin
        model_idle(ab);
        if (!ab) model_sweep(ab);
      end
    end
  end

  // Main sequence helpers.
  task automatic fill_tables(input int kind);
    for (int i = 0; i < 64; i++) begin
      tb_name[i]  = {8'($urandom), 32'($urandom)};
      tb_val[i]   = $urandom;
      tb_valid[i] = (kind == 2 && i != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (kind == 0) begin
      for (int i = 1; i <= 5; i++) tb_valid[i] = 1'b1;
      tb_name[1] = "SRC_1"; tb_val[1] = 32'h12345678;
      tb_name[2] = "SRC_2"; tb_val[2] = 32'h0000000F;
      tb_name[3] = "CONTR"; tb_val[3] = 32'h00000003;
      tb_name[4] = "RESUL"; tb_val[4] = 32'h12345687;
      tb_name[5] = "ODD  "; tb_val[5] = 32'h00000000;
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int i;
    i = 0;
    while (done_t.size() < n && i < budget) begin
      @(negedge clk); #2;
      i++;
    end
    chk("sweep_done arrival", done_t.size() >= n, 1);
  endtask

  initial begin : main
    int i;
    fill_tables(0);
    #1;
    chk("initial display_number", display_number, 0);
    chk("initial sweep_cnt", sweep_cnt, 0);
    chk("initial busy", busy, 0);

    // Five named slots, renderer always ready.
    release_reset();
    wait_done(1, 400);
    chk("A done cycle", done_t[0], 138);
    chk("A sweep_cnt", sweep_cnt, 1);
    chk("A record count", hs_slots.size(), 5);
    for (int k = 0; k < 5 && k < hs_slots.size(); k++) chk("A record slot", hs_slots[k], k + 1);

    // Renderer stalls the slot-4 record for 20 cycles.
    assert_reset();
    rdy_mode = 2; stall_slot = 4; stall_sweep = 0; stall_len = 20;
    release_reset();
    wait_done(1, 500);
    chk("B slot4 valid cycles", v4cnt, 21);
    chk("B done cycle", done_t[0], 158);
    chk("B record count", hs_slots.size(), 5);

    // All slots invalid: two timer-driven sweeps.
    assert_reset();
    rdy_mode = 0;
    fill_tables(1);
    release_reset();
    wait_done(2, 600);
    chk("C first done", done_t[0], 133);
    chk("C second done", done_t[1], 276);
    chk("C no records", any_rv, 0);

    // Two force pulses mid-sweep collapse into one immediate follow-up sweep.
    assert_reset();
    force_at1 = 30; force_at2 = 60;
    release_reset();
    wait_done(3, 800);
    chk("E first done", done_t[0], 133);
    chk("E forced done", done_t[1], 266);
    chk("E timer done", done_t[2], 409);
    force_at1 = -1; force_at2 = -1;

    // Reset while the slot-3 record of the second sweep is stalled.
    assert_reset();
    fill_tables(0);
    rdy_mode = 2; stall_slot = 3; stall_sweep = 1; stall_len = 100000;
    release_reset();
    i = 0;
    while (!(rec_valid && rec_slot == 6'd3 && sweep_cnt == 16'd1) && i < 800) begin
      @(negedge clk);
      i++;
    end
    chk("F reached stalled slot 3", i < 800, 1);
    reset = 1'b1;
    #1;
    chk("F async rec_valid", rec_valid, 0);
    chk("F async display_number", display_number, 0);
    chk("F async sweep_cnt", sweep_cnt, 0);
    chk("F async busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #2;
    chk("F restart slot", display_number, 1);
    wait_done(1, 400);
    chk("F restart done", done_t[0], 138);

    // Random validity, names, values, renderer readiness and force pulses.
    assert_reset();
    fill_tables(2);
    rdy_mode = 1;
    release_reset();
    repeat ($urandom_range(1200, 2200)) @(negedge clk);
    assert_reset();
    release_reset();
    repeat (2500) @(negedge clk);
    #2;
    chk("D records seen", hs_slots.size() > 0, 1);
    chk("D sweeps seen", done_t.size() > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
